ffn_eltwise_ctrl: RTL and testbench
===================================

FFN_ELTWISE_CTRL -- requirements
Module: ffn_eltwise_ctrl

Interface
REQ-001 Parameter BW_FP, 17, bit width of one FP lane.
REQ-002 Parameter VALUE_MN, 64, lanes per beat.
REQ-003 Parameter BW_CNT, 8, width of the beat counter and `num_beats`.
REQ-004 Parameter FMA_LAT, 2, cycles from issue until FMA_out is valid; legal range 1..8.
REQ-005 Parameter MODE_MUL, 5'b00010, per-lane FMA mode code for multiply.
REQ-006 Parameter MODE_ADD, 5'b00001, per-lane FMA mode code for add.
REQ-007 clk  in  1  sole clock, rising edge.
REQ-008 rst  in  1  reset, synchronous, active-high.
REQ-009 start  in  1  one-cycle job request.
REQ-010 op_sel  in  1  0=MUL, 1=ADD; sampled with start.
REQ-011 num_beats  in  BW_CNT  beats in the job; sampled with start.
REQ-012 in_valid  in  1  a_in/b_in beat valid.
REQ-013 in_ready  out  1  controller accepts a beat.
REQ-014 a_in, b_in  in  VALUE_MN*BW_FP  operand vectors.
REQ-015 FMA_out  in  VALUE_MN*BW_FP  shared FMA array result.
REQ-016 busy  out  1  job in progress.
REQ-017 mode_fma  out  VALUE_MN*5  per-lane FMA mode.
REQ-018 a_fma, b_fma  out  VALUE_MN*BW_FP  FMA operands.
REQ-019 out_data  out  VALUE_MN*BW_FP  registered result.
REQ-020 out_valid, out_last  out  1  result valid; final beat of the job.
REQ-021 done  out  1  one-cycle job-complete pulse.

Function
REQ-022 FSM states: IDLE, RUN, DRAIN.
REQ-023 IDLE & start & num_beats!=0 -> RUN next cycle; latch op_sel and num_beats; busy=1 from the next cycle.
REQ-024 IDLE & start & num_beats==0 -> stay IDLE; done pulses the next cycle; no issue, no out_valid.
REQ-025 start while busy=1 is ignored and has no effect on any state.
REQ-026 in_ready=1 only in RUN; a beat is accepted in any cycle with in_valid & in_ready.
REQ-027 Accept cycle issue (combinational): a_fma=a_in, b_fma=b_in, mode_fma=latched code replicated VALUE_MN times.
REQ-028 Non-accept cycles: mode_fma, a_fma and b_fma are all zeros.
REQ-029 Issue counter increments per accept; the accept of beat num_beats moves RUN->DRAIN.
REQ-030 Valid/last tag shift register is FMA_LAT deep; an accept at cycle t captures FMA_out at the end of cycle t+FMA_LAT.
REQ-031 The captured result is presented with out_valid=1 in cycle t+FMA_LAT+1, i.e. accept-to-out_valid latency is FMA_LAT+1.
REQ-032 out_data holds its value when out_valid=0.
REQ-033 out_last=1 only with the out_valid of the job's final beat.
REQ-034 done=1 in the same cycle as out_valid & out_last.
REQ-035 DRAIN -> IDLE in the done cycle; busy=0 from the following cycle; start is accepted that cycle.
REQ-036 Back-to-back accepts (in_valid held high) yield one result per cycle, in order, with no bubbles.
REQ-037 Gaps in in_valid propagate as identical gaps in out_valid.
REQ-038 num_beats = 2^BW_CNT-1 completes without counter wrap.

Reset
REQ-039 rst=1 at a clock edge forces state IDLE, counters and tags to 0, busy/out_valid/out_last/done/in_ready=0, out_data=0, and FMA drive outputs to 0.
REQ-040 Reset mid-job discards all in-flight results; no out_valid or done for that job.
REQ-041 The first start is honoured one cycle after rst deasserts.

Verification
REQ-042 FMA_LAT=2, op_sel=0, num_beats=1, beat accepted at cycle 2 -> mode_fma lanes=5'b00010 at cycle 2 only; out_valid/out_last/done at cycle 5; busy low at cycle 6.
REQ-043 num_beats=4, in_valid continuous, op_sel=1 -> mode lanes=5'b00001 on 4 consecutive cycles; 4 consecutive out_valid; out_last only on the 4th; data equals the FMA model output in order.
REQ-044 num_beats=3 with in_valid pattern 1,0,1,1 -> out_valid pattern 1,0,1,1 shifted by FMA_LAT+1 cycles.
REQ-045 start during RUN with different op_sel/num_beats -> ignored; original count and mode are retained.
REQ-046 num_beats=0 -> done next cycle, busy stays 0, in_ready stays 0.
REQ-047 rst during DRAIN with 2 beats in flight -> no out_valid or done afterwards; the next job (num_beats=1) completes normally.

Source files
------------

// File: rtl/ffn_eltwise_ctrl_if.sv
// ffn_eltwise_ctrl_if: job/beat handshake and FMA bus bundle; master=job source+FMA array side, slave=controller (start/op_sel/num_beats/in_valid/a_in/b_in/FMA_out in; in_ready/busy/mode_fma/a_fma/b_fma/out_data/out_valid/out_last/done out)
interface ffn_eltwise_ctrl_if #(
  parameter int BW_FP    = 17,
  parameter int VALUE_MN = 64,
  parameter int BW_CNT   = 8
);
  logic                      start;
  logic                      op_sel;
  logic [BW_CNT-1:0]         num_beats;
  logic                      in_valid;
  logic                      in_ready;
  logic [VALUE_MN*BW_FP-1:0] a_in;
  logic [VALUE_MN*BW_FP-1:0] b_in;
  logic [VALUE_MN*BW_FP-1:0] FMA_out;
  logic                      busy;
  logic [VALUE_MN*5-1:0]     mode_fma;
  logic [VALUE_MN*BW_FP-1:0] a_fma;
  logic [VALUE_MN*BW_FP-1:0] b_fma;
  logic [VALUE_MN*BW_FP-1:0] out_data;
  logic                      out_valid;
  logic                      out_last;
  logic                      done;
  modport master (
    output start, op_sel, num_beats, in_valid, a_in, b_in, FMA_out,
    input  in_ready, busy, mode_fma, a_fma, b_fma, out_data, out_valid, out_last, done
  );
  modport slave (
    input  start, op_sel, num_beats, in_valid, a_in, b_in, FMA_out,
    output in_ready, busy, mode_fma, a_fma, b_fma, out_data, out_valid, out_last, done
  );
endinterface

// File: rtl/ffn_eltwise_ctrl.sv
// ffn_eltwise_ctrl: issues num_beats operand beats to a shared FMA array and registers its results FMA_LAT+1 cycles later; ports clk, rst (sync active-high), bus (ffn_eltwise_ctrl_if.slave)
module ffn_eltwise_ctrl #(
  parameter int         BW_FP    = 17,
  parameter int         VALUE_MN = 64,
  parameter int         BW_CNT   = 8,
  parameter int         FMA_LAT  = 2,
  parameter logic [4:0] MODE_MUL = 5'b00010,
  parameter logic [4:0] MODE_ADD = 5'b00001
) (
  input logic clk,
  input logic rst,
  ffn_eltwise_ctrl_if.slave bus
);
  localparam int W = VALUE_MN * BW_FP;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t            state_q, state_d;
  logic              op_q;
  logic [BW_CNT-1:0] nb_q, cnt_q;
  logic [FMA_LAT-1:0] vld_q, lst_q;
  logic [W-1:0]      out_q;
  logic              ov_q, ol_q, zd_q;
  logic              acc, acc_last, fin, go;
  always_comb begin
    go       = state_q == IDLE && bus.start;
    acc      = state_q == RUN && bus.in_valid;
    acc_last = acc && cnt_q == nb_q - BW_CNT'(1);
    fin      = ov_q && ol_q;
    state_d  = state_q;
    if (go && bus.num_beats != '0) state_d = RUN;
    else if (acc_last) state_d = DRAIN;
    else if (state_q == DRAIN && fin) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q  <= 1'b0;
      nb_q  <= '0;
      cnt_q <= '0;
      vld_q <= '0;
      lst_q <= '0;
      out_q <= '0;
      ov_q  <= 1'b0;
      ol_q  <= 1'b0;
      zd_q  <= 1'b0;
    end else begin
      zd_q <= go && bus.num_beats == '0;
      if (go) begin
        op_q  <= bus.op_sel;
        nb_q  <= bus.num_beats;
        cnt_q <= '0;
      end else if (acc) cnt_q <= cnt_q + BW_CNT'(1);
      // tag pipeline mirrors the FMA latency so each result is captured the cycle it is valid
      vld_q <= FMA_LAT'({vld_q, acc});
      lst_q <= FMA_LAT'({lst_q, acc_last});
      ov_q  <= vld_q[FMA_LAT-1];
      ol_q  <= lst_q[FMA_LAT-1];
      if (vld_q[FMA_LAT-1]) out_q <= bus.FMA_out;
    end
  end
  assign bus.in_ready  = state_q == RUN;
  assign bus.busy      = state_q != IDLE;
  assign bus.mode_fma  = acc ? {VALUE_MN{op_q ? MODE_ADD : MODE_MUL}} : '0;
  assign bus.a_fma     = acc ? bus.a_in : '0;
  assign bus.b_fma     = acc ? bus.b_in : '0;
  assign bus.out_data  = out_q;
  assign bus.out_valid = ov_q;
  assign bus.out_last  = ol_q;
  assign bus.done      = fin || zd_q;
endmodule

// File: tb/tb_ffn_eltwise_ctrl.sv
// tb_ffn_eltwise_ctrl: directed self-checking bench with a 2-cycle FMA array model
module tb_ffn_eltwise_ctrl;
  localparam int BW_FP = 17;
  localparam int VM    = 4;
  localparam int W     = VM * BW_FP;
  logic clk = 1'b0;
  logic rst;
  int ntests = 0;
  int nfail  = 0;
  logic [W-1:0] q[$];
  logic [W-1:0] f0, f1, last_d;
  ffn_eltwise_ctrl_if #(.BW_FP(BW_FP), .VALUE_MN(VM), .BW_CNT(8)) bus ();
  ffn_eltwise_ctrl #(.BW_FP(BW_FP), .VALUE_MN(VM), .BW_CNT(8), .FMA_LAT(2)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  function automatic logic [W-1:0] fmaf(logic [W-1:0] a, logic [W-1:0] b, logic [VM*5-1:0] m);
    return a ^ {b[W-2:0], b[W-1]} ^ W'(m);
  endfunction
  function automatic logic [W-1:0] va(int j);
    return {17'(j * 3 + 1), 17'(j * 7 + 2), 17'(j * 11 + 3), 17'(j * 13 + 4)};
  endfunction
  function automatic logic [W-1:0] vb(int j);
    return {17'(j + 100), 17'(j * 2 + 200), 17'(j * 5 + 300), 17'(j * 9 + 400)};
  endfunction
  always @(posedge clk) begin
    f0 <= fmaf(bus.a_fma, bus.b_fma, bus.mode_fma);
    f1 <= f0;
  end
  assign bus.FMA_out = f1;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [W-1:0] o, input logic [W-1:0] e);
    ntests++;
    assert (o === e) else begin
      nfail++;
      $error("FAIL %s: got %h want %h", tag, o, e);
    end
  endtask
  task automatic run(input logic op, input int nb, input logic [15:0] pat, input int len, input logic inj);
    int acc, oc;
    logic iv, ev, lst;
    logic [VM*5-1:0] em;
    logic [W-1:0] ed;
    acc = 0;
    oc  = 0;
    q.delete();
    bus.start     = 1'b1;
    bus.op_sel    = op;
    bus.num_beats = 8'(nb);
    tick();
    for (int j = 0; j < len + 3; j++) begin
      iv = j < len && (len > 16 || pat[j]);
      ev = j >= 3 && (len > 16 || pat[j-3]);
      bus.in_valid  = iv;
      bus.a_in      = va(j);
      bus.b_in      = vb(j);
      bus.start     = inj && j == 1;
      bus.op_sel    = inj ? ~op : op;
      bus.num_beats = 8'(inj ? nb + 1 : nb);
      #1;
      em = iv ? (op ? {VM{5'b00001}} : {VM{5'b00010}}) : '0;
      chk("in_ready", W'(bus.in_ready), W'(acc < nb));
      chk("busy_run", W'(bus.busy), W'(1));
      chk("mode_fma", W'(bus.mode_fma), W'(em));
      chk("a_fma", bus.a_fma, iv ? va(j) : '0);
      chk("b_fma", bus.b_fma, iv ? vb(j) : '0);
      lst = ev && oc + 1 == nb;
      chk("out_valid", W'(bus.out_valid), W'(ev));
      chk("out_last", W'(bus.out_last), W'(lst));
      chk("done", W'(bus.done), W'(lst));
      if (ev) begin
        ed = q.pop_front();
        last_d = ed;
        chk("out_data", bus.out_data, ed);
        oc++;
      end
      if (iv) begin
        q.push_back(fmaf(va(j), vb(j), em));
        acc++;
      end
      tick();
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    #1;
    chk("busy_end", W'(bus.busy), W'(0));
    chk("in_ready_end", W'(bus.in_ready), W'(0));
    chk("out_valid_end", W'(bus.out_valid), W'(0));
    chk("done_end", W'(bus.done), W'(0));
    chk("out_data_hold", bus.out_data, last_d);
  endtask
  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.op_sel = 1'b0;
    bus.num_beats = '0;
    bus.in_valid = 1'b0;
    bus.a_in = '0;
    bus.b_in = '0;
    tick();
    tick();
    chk("rst_busy", W'(bus.busy), W'(0));
    chk("rst_in_ready", W'(bus.in_ready), W'(0));
    chk("rst_out_valid", W'(bus.out_valid), W'(0));
    chk("rst_done", W'(bus.done), W'(0));
    chk("rst_out_data", bus.out_data, '0);
    chk("rst_mode", W'(bus.mode_fma), W'(0));
    rst = 1'b0;
    run(1'b0, 1, 16'h0001, 1, 1'b0);
    run(1'b1, 4, 16'h000F, 4, 1'b1);
    run(1'b0, 3, 16'b1101, 4, 1'b0);
    bus.start = 1'b1;
    bus.num_beats = 8'd0;
    tick();
    bus.start = 1'b0;
    chk("zero_done", W'(bus.done), W'(1));
    chk("zero_busy", W'(bus.busy), W'(0));
    chk("zero_ready", W'(bus.in_ready), W'(0));
    tick();
    chk("zero_done_clr", W'(bus.done), W'(0));
    chk("zero_busy2", W'(bus.busy), W'(0));
    bus.start = 1'b1;
    bus.op_sel = 1'b0;
    bus.num_beats = 8'd2;
    tick();
    bus.start = 1'b0;
    bus.in_valid = 1'b1;
    bus.a_in = va(50);
    bus.b_in = vb(50);
    tick();
    tick();
    bus.in_valid = 1'b0;
    #1;
    chk("drain_ready", W'(bus.in_ready), W'(0));
    chk("drain_busy", W'(bus.busy), W'(1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("rstjob_valid", W'(bus.out_valid), W'(0));
      chk("rstjob_done", W'(bus.done), W'(0));
      chk("rstjob_busy", W'(bus.busy), W'(0));
      tick();
    end
    run(1'b0, 1, 16'h0001, 1, 1'b0);
    run(1'b1, 255, 16'h0000, 255, 1'b0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
